seg_scan_driver: RTL and testbench
==================================

Name: seg_scan_driver

Overview:
- Consumer end of the ATM display interface. Takes the four 7-segment patterns (digit4..digit1) and four decimal points from the atm core.
- Time-multiplexes them onto the Basys common-anode display, which has active-low anodes and active-low segments.
- Latches each frame in shadow registers so a frame never tears, inserts anode dead time against ghosting, and supports per-digit blinking (used for lock/error indication) plus global blanking.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot (1 ms at 100 MHz); legal range >= 2.
- DEAD_CYCLES, 1000: cycles at the start of each slot with all anodes off; 0 <= DEAD_CYCLES < REFRESH_DIV.
- BLINK_FRAMES, 125: full frames per blink half-period (0.5 s at defaults); >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- digit1  in  7  rightmost digit pattern, bit0=a .. bit6=g, 1 = segment lit
- digit2  in  7  pattern for digit 2
- digit3  in  7  pattern for digit 3
- digit4  in  7  leftmost digit pattern
- dp_in  in  4  decimal point per digit, bit0 = digit1, 1 = lit
- blink_en  in  4  per-digit blink enable, bit0 = digit1
- blank  in  1  1 = display fully dark
- an  out  4  anodes, active-low, an[0] = digit1
- seg  out  7  segments, active-low, seg[0] = a
- dp  out  1  decimal point, active-low
- frame_tick  out  1  one-cycle pulse at the end of each full 4-slot frame

Behaviour:
- Reset (rst=0, asynchronous): an=4'b1111, seg=7'h7F, dp=1, frame_tick=0. Internal state cleared: slot counter p=0, index idx=0, frame counter=0, blink_phase=0 (visible), shadow registers=0.
- Counters:
  - p counts 0..REFRESH_DIV-1 and then wraps.
  - On wrap, idx advances 0->1->2->3->0.
  - Frame end is the cycle where p=REFRESH_DIV-1 and idx=3.
- Shadow load: when p=0 and idx=0, digit1..4, dp_in and blink_en are captured. This includes the first cycle after reset release. The display uses only the shadow copies, so input changes mid-frame appear from the next frame.
- Blink:
  - The frame counter increments at each frame end.
  - When it reaches BLINK_FRAMES-1 at a frame end, it clears and blink_phase toggles.
  - Digit k is dark while shadow_blink[k]=1 and blink_phase=1.
- Outputs are registered with 1-cycle latency from the counter state (p, idx). For counter state (p, idx):
  - an = 4'b1111 if blank=1, or if p < DEAD_CYCLES; otherwise an = ~(4'b0001 << idx).
  - seg = 7'h7F if the slot is dark (blank, or blink-dark digit); otherwise seg = ~shadow_digit[idx].
  - dp = 1 if the slot is dark; otherwise dp = ~shadow_dp[idx].
- blank is not frame-latched. It takes effect on the next clock edge and releases on the next edge.
- frame_tick is registered and is high on the cycle after the frame-end counter state, aligned with the last slot's final output cycle + 1.
- Reset mid-frame: outputs go dark immediately. After release the driver restarts at idx=0, p=0 and reloads the shadow registers.
- No combinational path from any input to any output.

Decomposition:
- Shared package ssd_pkg:
  - segment bit-order constants (SEG_A..SEG_G)
  - ALL_OFF_SEG = 7'h7F and ALL_OFF_AN = 4'hF
  - default timing constants for a 100 MHz clk
- One natural sub-module, ssd_timebase: holds p, idx and the frame/blink counters, and emits slot_start, dead, frame_end and blink_phase.
- The top level holds the shadow registers and the output mux/registers.

Test Plan:
All scenarios use REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2.
1. Reset: hold rst=0 for 5 cycles with random inputs -> an=1111, seg=7F, dp=1, frame_tick=0 throughout; drop rst mid-slot later -> outputs dark within the same cycle (asynchronous).
2. Scan: digit1=06, digit2=5B, digit3=4F, digit4=66, dp_in=0010 -> each slot shows 2 cycles of an=1111, then 6 cycles of an=1110/1101/1011/0111 with seg=79/24/30/19. dp=0 only in the an=1101 slot. frame_tick pulses every 32 cycles.
3. Tear-free: change digit3 from 4F to 7F at cycle 10 of a frame -> the an=1011 slot of that frame still shows seg=30; the next frame shows seg=00.
4. Blink: blink_en=0100 -> the digit3 slot shows seg=30 in frames 0-1, 7F with an=1011 in frames 2-3, and 30 again in frames 4-5. Other digits are unaffected.
5. Blank: blank=1 for 5 cycles mid-slot -> an=1111, seg=7F, dp=1 starting one cycle later. On release, scanning resumes at the current idx/p with no counter disturbance.
6. Reset mid-operation: assert rst in slot idx=2 at p=5, release, and change digit1 to 3F -> the first output slot after release is an=1110 (after 2 dead cycles) with seg=40.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared constants and helpers for the 7-segment scan driver.
// Timing defaults assume a 100 MHz system clock.
package ssd_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] ALL_OFF_SEG = 7'h7F;
  localparam logic [3:0] ALL_OFF_AN  = 4'hF;

  localparam int DEF_REFRESH_DIV  = 100000;
  localparam int DEF_DEAD_CYCLES  = 1000;
  localparam int DEF_BLINK_FRAMES = 125;

  typedef logic [1:0] digit_idx_t;

  // Active-low one-cold anode select for the digit being scanned.
  function automatic logic [3:0] anode_sel(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/ssd_timebase.sv
// Slot/frame timebase: slot position p, digit index, frame counter and blink phase.
// All status outputs are decoded from the current counter state.
module ssd_timebase
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  output digit_idx_t idx,
  output logic       slot_start,
  output logic       dead,
  output logic       frame_end,
  output logic       blink_phase
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] P_DEAD = PW'(DEAD_CYCLES);
  localparam logic [FW-1:0] F_LAST = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] p;
  logic [FW-1:0] frame_cnt;

  always_comb begin
    slot_start = (p == '0);
    dead       = (p < P_DEAD);
    frame_end  = (p == P_LAST) && (idx == 2'd3);
  end

  // Blink phase flips every BLINK_FRAMES completed frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      p           <= '0;
      idx         <= '0;
      frame_cnt   <= '0;
      blink_phase <= 1'b0;
    end else begin
      if (p == P_LAST) begin
        p   <= '0;
        idx <= idx + 2'd1;
      end else begin
        p <= p + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == F_LAST) begin
          frame_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode display with
// frame-latched patterns, anode dead time, per-digit blink and global blank.
module seg_scan_driver
  import ssd_pkg::*;
#(
  parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
  parameter int DEAD_CYCLES  = DEF_DEAD_CYCLES,
  parameter int BLINK_FRAMES = DEF_BLINK_FRAMES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] digit1,
  input  logic [6:0] digit2,
  input  logic [6:0] digit3,
  input  logic [6:0] digit4,
  input  logic [3:0] dp_in,
  input  logic [3:0] blink_en,
  input  logic       blank,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_tick
);

  digit_idx_t idx;
  logic       slot_start;
  logic       dead;
  logic       frame_end;
  logic       blink_phase;

  ssd_timebase #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .idx        (idx),
    .slot_start (slot_start),
    .dead       (dead),
    .frame_end  (frame_end),
    .blink_phase(blink_phase)
  );

  logic [SEG_G:SEG_A] shadow_digit [4];
  logic [3:0]         shadow_dp;
  logic [3:0]         shadow_blink;

  logic               load;
  logic [SEG_G:SEG_A] eff_digit;
  logic               eff_dp;
  logic               eff_blink;
  logic               dark;
  logic [3:0]         next_an;
  logic [6:0]         next_seg;
  logic               next_dp;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shadow_digit[0] <= '0;
      shadow_digit[1] <= '0;
      shadow_digit[2] <= '0;
      shadow_digit[3] <= '0;
      shadow_dp       <= '0;
      shadow_blink    <= '0;
    end else if (load) begin
      shadow_digit[0] <= digit1;
      shadow_digit[1] <= digit2;
      shadow_digit[2] <= digit3;
      shadow_digit[3] <= digit4;
      shadow_dp       <= dp_in;
      shadow_blink    <= blink_en;
    end
  end

  // On the load cycle the shadows still hold the previous frame, so the
  // first output of the new frame is taken straight from the incoming digit1.
  always_comb begin
    load      = slot_start && (idx == 2'd0);
    eff_digit = load ? digit1      : shadow_digit[idx];
    eff_dp    = load ? dp_in[0]    : shadow_dp[idx];
    eff_blink = load ? blink_en[0] : shadow_blink[idx];
    dark      = blank || (eff_blink && blink_phase);
    next_an   = (blank || dead) ? ALL_OFF_AN : anode_sel(idx);
    next_seg  = dark ? ALL_OFF_SEG : ~eff_digit;
    next_dp   = dark ? 1'b1 : ~eff_dp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an         <= ALL_OFF_AN;
      seg        <= ALL_OFF_SEG;
      dp         <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      an         <= next_an;
      seg        <= next_seg;
      dp         <= next_dp;
      frame_tick <= frame_end;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: a time-indexed reference model
// checked every cycle, plus hand-computed literal checkpoints.
module tb_seg_scan_driver;

  localparam int R     = 8;
  localparam int DC    = 2;
  localparam int BF    = 2;
  localparam int FRAME = 4 * R;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] digit1 = '0, digit2 = '0, digit3 = '0, digit4 = '0;
  logic [3:0] dp_in = '0, blink_en = '0;
  logic       blank = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_tick;

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  seg_scan_driver #(
    .REFRESH_DIV (R),
    .DEAD_CYCLES (DC),
    .BLINK_FRAMES(BF)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .digit1    (digit1),
    .digit2    (digit2),
    .digit3    (digit3),
    .digit4    (digit4),
    .dp_in     (dp_in),
    .blink_en  (blink_en),
    .blank     (blank),
    .an        (an),
    .seg       (seg),
    .dp        (dp),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model: t counts clock edges since reset release; slot, position
  // and frame follow by division, and each frame's patterns are captured at its start.
  int         t = 0;
  logic [6:0] sh_dig [4];
  logic [3:0] sh_dp  = '0;
  logic [3:0] sh_bl  = '0;
  logic [11:0] exp_vec  = {4'hF, 7'h7F, 1'b1};
  logic        exp_tick = 1'b0;

  function automatic logic [11:0] model_out(input int tt);
    int         slot;
    int         pos;
    bit         first;
    logic [6:0] pat;
    logic       dpb, blb, phase, dark;
    logic [3:0] a;
    logic [6:0] s;
    logic       d;
    slot  = (tt / R) % 4;
    pos   = tt % R;
    first = (tt % FRAME) == 0;
    pat   = first ? digit1      : sh_dig[slot];
    dpb   = first ? dp_in[0]    : sh_dp[slot];
    blb   = first ? blink_en[0] : sh_bl[slot];
    phase = (((tt / FRAME) / BF) % 2) == 1;
    dark  = blank || (blb && phase);
    a = 4'hF;
    if (!blank && pos >= DC) a[slot] = 1'b0;
    s = dark ? 7'h7F : ~pat;
    d = dark ? 1'b1 : ~dpb;
    return {a, s, d};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      t        <= 0;
      exp_vec  <= {4'hF, 7'h7F, 1'b1};
      exp_tick <= 1'b0;
      sh_dig   <= '{default: 7'h00};
      sh_dp    <= '0;
      sh_bl    <= '0;
    end else begin
      if (t % FRAME == 0) begin
        sh_dig <= '{digit1, digit2, digit3, digit4};
        sh_dp  <= dp_in;
        sh_bl  <= blink_en;
      end
      exp_vec  <= model_out(t);
      exp_tick <= (t % FRAME) == FRAME - 1;
      t        <= t + 1;
    end
  end

  task automatic tally(input bit ok, input string name, input logic [11:0] act, input logic [11:0] req);
    checks++;
    if (ok) passes++;
    else $display("[TB] FAIL %s at %0t: got %h required %h", name, $time, act, req);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      tally({an, seg, dp} === exp_vec, "model_out", {an, seg, dp}, exp_vec);
      tally(frame_tick === exp_tick, "model_tick", {11'd0, frame_tick}, {11'd0, exp_tick});
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] a, input logic [6:0] s, input logic d);
    tally({an, seg, dp} === {a, s, d}, name, {an, seg, dp}, {a, s, d});
  endtask

  task automatic checkTick(input string name, input logic v);
    tally(frame_tick === v, name, {11'd0, frame_tick}, {11'd0, v});
  endtask

  task automatic applyStimulus(input logic [6:0] d1, d2, d3, d4, input logic [3:0] dpv, blv, input logic bk);
    digit1 = d1; digit2 = d2; digit3 = d3; digit4 = d4;
    dp_in = dpv; blink_en = blv; blank = bk;
  endtask

  // Returns at the falling edge where outputs reflect counter state n.
  task automatic goto(input int n);
    int guard = 0;
    while (t != n + 1 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (t != n + 1) tally(1'b0, "goto_timeout", t[11:0], 12'(n + 1));
  endtask

  initial begin
    @(posedge clk);
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      applyStimulus(7'($urandom), 7'($urandom), 7'($urandom), 7'($urandom),
                    4'($urandom), 4'($urandom), 1'($urandom));
      checkOutput("reset_hold", 4'hF, 7'h7F, 1'b1);
      checkTick("reset_tick", 1'b0);
    end

    applyStimulus(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0010, 4'b0000, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    goto(0);   checkOutput("scan_dead", 4'hF, 7'h79, 1'b1);
    goto(2);   checkOutput("scan_d1", 4'b1110, 7'h79, 1'b1);
    goto(10);  checkOutput("scan_d2_dp", 4'b1101, 7'h24, 1'b0);
    goto(18);  checkOutput("scan_d3", 4'b1011, 7'h30, 1'b1);
    goto(26);  checkOutput("scan_d4", 4'b0111, 7'h19, 1'b1);
    goto(30);  checkTick("tick_low", 1'b0);
    goto(31);  checkTick("tick_frame0", 1'b1);

    goto(41);
    digit3 = 7'h7F;
    goto(50);  checkOutput("tear_same_frame", 4'b1011, 7'h30, 1'b1);
    goto(63);  checkTick("tick_frame1", 1'b1);
    goto(82);  checkOutput("tear_next_frame", 4'b1011, 7'h00, 1'b1);

    @(negedge clk);
    rst = 1'b0;
    applyStimulus(7'h06, 7'h5B, 7'h4F, 7'h66, 4'b0010, 4'b0100, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    goto(18);  checkOutput("blink_f0", 4'b1011, 7'h30, 1'b1);
    goto(50);  checkOutput("blink_f1", 4'b1011, 7'h30, 1'b1);
    goto(66);  checkOutput("blink_f2_d1", 4'b1110, 7'h79, 1'b1);
    goto(82);  checkOutput("blink_f2_dark", 4'b1011, 7'h7F, 1'b1);
    goto(114); checkOutput("blink_f3_dark", 4'b1011, 7'h7F, 1'b1);
    goto(146); checkOutput("blink_f4_lit", 4'b1011, 7'h30, 1'b1);

    goto(164); checkOutput("blank_before", 4'b1110, 7'h79, 1'b1);
    blank = 1'b1;
    goto(165); checkOutput("blank_on", 4'hF, 7'h7F, 1'b1);
    goto(169); checkOutput("blank_held", 4'hF, 7'h7F, 1'b1);
    blank = 1'b0;
    goto(170); checkOutput("blank_release", 4'b1101, 7'h24, 1'b0);
    goto(178); checkOutput("blink_f5_lit", 4'b1011, 7'h30, 1'b1);

    goto(180);
    #1 rst = 1'b0;
    #1 checkOutput("async_reset", 4'hF, 7'h7F, 1'b1);
    checkTick("async_reset_tick", 1'b0);
    digit1 = 7'h3F;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    goto(1);   checkOutput("restart_dead", 4'hF, 7'h40, 1'b1);
    goto(2);   checkOutput("restart_d1", 4'b1110, 7'h40, 1'b1);
    goto(40);

    chk_en = 1'b0;
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
